// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_pkg                                                    |
// | Shared constants, FSM encoding and helpers for the two-port        |
// | memory arbiter.                                                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_arbiter_pkg;

  // Port indices: instruction fetch on port 0, load/store unit on port 1.
  localparam int PORT_IF   = 0;
  localparam int PORT_LSU  = 1;
  localparam int NUM_PORTS = 2;

  // Default widths, matching the shared main memory.
  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 32;

  // Sequencer states. IDLE accepts a request, ISSUE holds the memory
  // command for exactly one cycle, WAIT sits until the memory completes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // One-hot port vector from a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    port_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_rr_arb2                                                |
// | rr_arb2: combinational two-way round-robin pick. A lone requester  |
// | wins; on contention the port that did not win last time wins.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] winner
);

  // One-hot winner; zero when nobody requests.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = port_onehot(~last_grant);
      default: winner = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter                                                        |
// | Two-port round-robin arbiter and sequencer in front of a shared    |
// | single-port latency-based memory. One transaction in flight; the   |
// | winner's request is latched, issued for one cycle, and the         |
// | completion is routed back to the owning port.                      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_re,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_done
);

  // Sequencer state and transaction context.
  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  op_we_q, op_we_d;

  // Registered outputs. mem_addr/mem_wdata double as the latched
  // address/data of the current transaction and hold between issues.
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Winner of the current pick and its payload.
  logic [1:0]            win_oh;
  logic                  win_idx;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (win_oh)
  );

  // Select the winning port's write flag, address and write data.
  always_comb begin
    win_idx   = win_oh[PORT_LSU];
    win_we    = win_idx ? we[PORT_LSU] : we[PORT_IF];
    win_addr  = win_idx ? addr1 : addr0;
    win_wdata = win_idx ? wdata1 : wdata0;
  end

  // Next-state and output logic; pulses default low, context holds.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_we_d      = op_we_q;
    gnt_d        = 2'b00;
    resp_valid_d = 2'b00;
    rdata_d      = rdata_q;
    mem_en_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|win_oh) begin
          owner_d      = win_idx;
          op_we_d      = win_we;
          last_grant_d = win_idx;
          mem_addr_d   = win_addr;
          mem_wdata_d  = win_wdata;
          gnt_d        = win_oh;
          mem_en_d     = 1'b1;
          mem_re_d     = ~win_we;
          mem_wr_d     = win_we;
          state_d      = ST_ISSUE;
        end
      end

      // The memory samples the command on this edge; qualifiers drop
      // back to zero through the defaults above.
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      // A write completion leaves rdata untouched.
      ST_WAIT: begin
        if (mem_done) begin
          if (!op_we_q) begin
            rdata_d = mem_rdata;
          end
          resp_valid_d = port_onehot(owner_q);
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_we_q      <= 1'b0;
      gnt_q        <= 2'b00;
      resp_valid_q <= 2'b00;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_we_q      <= op_we_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_re_q     <= mem_re_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_re     = mem_re_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the shared single-port main memory (latency-based, en/re/wr request, one-cycle done pulse).
- Port 0 serves instruction fetch; port 1 serves the load/store unit.
- Latches the winning request, drives a one-cycle issue, waits for completion and routes the response back to the owning port.
- Only one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 20: byte-address width, equal to the memory's ADDR_WIDTH.
- DATA_WIDTH, 32: data word width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-port request level; bit i = port i.
- we  in  2  per-port write flag (1 = write, 0 = read), valid with req.
- addr0, addr1  in  ADDR_WIDTH  per-port address.
- wdata0, wdata1  in  DATA_WIDTH  per-port write data.
- gnt  out  2  one-hot, one-cycle pulse: the port's request has been latched.
- resp_valid  out  2  one-hot, one-cycle pulse: the port's transaction is complete.
- rdata  out  DATA_WIDTH  read data, valid while resp_valid is high for a read.
- mem_en, mem_re, mem_wr  out  1 each  memory command.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory data_out.
- mem_done  in  1  memory completion pulse.

Behaviour:
- Outputs: all outputs are registered. On reset (async, rst_n=0): gnt=0, resp_valid=0, rdata=0, mem_en/re/wr=0, mem_addr=0, mem_wdata=0; state=IDLE; last_grant=1, so port 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req bit is set, pick the winner. With one requester, that port wins. With both, the port != last_grant wins.
  - Latch the winner's we/addr/wdata into owner/op/addr/data registers, update last_grant.
  - Pulse gnt[winner]; set mem_en=1, mem_re=~we, mem_wr=we; go to ISSUE.
- ISSUE: lasts exactly one cycle. The memory samples the command at this edge. Clear mem_en/re/wr; go to WAIT.
- WAIT:
  - On mem_done=1: if op is read, rdata<=mem_rdata (otherwise rdata holds). Pulse resp_valid[owner]; go to IDLE.
  - mem_done observed in IDLE or ISSUE is ignored.
- Requester rules:
  - Hold req and payload stable until gnt is seen; deassert req the cycle after gnt.
  - The payload may change after gnt.
  - A req still high when the FSM re-enters IDLE is treated as a new request.
- Latency: req sampled at edge E0 -> gnt high after E0 -> resp_valid high after E0+LATENCY+3 (LATENCY=10: 13 cycles).
- Throughput: earliest next grant is the edge after resp_valid, i.e. LATENCY+4 cycles per transaction.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1...
- Requests arriving while not in IDLE are not lost, since req is a level and is held by the requester. They are not queued internally.
- mem_addr and mem_wdata hold their last values outside ISSUE. Only mem_en/re/wr are qualifiers.
- Reset mid-transaction: return to IDLE and drop the in-flight transaction; no resp_valid is generated. The system resets the memory concurrently.

Decomposition:
- Shared package: port index constants PORT_IF=0, PORT_LSU=1, NUM_PORTS=2, the FSM state encoding (IDLE, ISSUE, WAIT), and default ADDR/DATA widths.
- Sub-module rr_arb2: combinational round-robin pick from req[1:0] and last_grant; outputs a one-hot winner. Everything else stays in mem_arbiter.

Test Plan:
- Single read: preload mem[0x00010]=0xA5; port 0 read addr 0x00010 -> gnt=2'b01 after 1 cycle; mem_re pulses once; resp_valid=2'b01 with rdata=0xA5, 13 cycles after req (LATENCY=10).
- Write then read: port 1 writes 0x3C to 0x00200, then reads 0x00200 -> exactly one mem_wr pulse, then one mem_re pulse; read resp rdata=0x3C; rdata unchanged after the write response.
- Simultaneous requests after reset: both req rise at the same edge -> port 0 granted first, port 1 granted on the edge after port 0's resp_valid; at most one mem_en pulse in flight.
- Continuous contention: both ports re-request immediately after each gnt, 6 transactions -> grant order 0,1,0,1,0,1; each port's resp_valid matches its own address/data.
- Late request: port 1 raises req while port 0's transaction is in WAIT -> no gnt[1] until IDLE; gnt[1] on the edge after resp_valid[0].
- Reset in WAIT: assert rst_n=0 for 2 cycles, 5 cycles into port 0's read -> all outputs 0 asynchronously, no resp_valid; after release a new port 1 request completes normally.
